// File: rtl/fact_job_sequencer.sv
// Bus-master sequencer that runs one factorial job on the memory-mapped core:
// program, start, wait (poll or interrupt), fetch result, store to memory, clear.
module fact_job_sequencer #(
  parameter logic [15:0] FACT_BASE = 16'h7000,
  parameter int unsigned POLL_GAP  = 8,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] operand,
  input  logic [15:0] dst_addr,
  input  logic        intr_mode,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] result_h,
  output logic [63:0] result_l,
  output logic        m_req,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout,
  input  logic        m_grant,
  input  logic [63:0] m_din,
  input  logic        interrupt
);

  localparam int unsigned GW = $clog2(POLL_GAP + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [15:0] OFS_OPSTART  = 16'h0000;
  localparam logic [15:0] OFS_OPCLEAR  = 16'h0008;
  localparam logic [15:0] OFS_OPDONE   = 16'h0010;
  localparam logic [15:0] OFS_INTREN   = 16'h0018;
  localparam logic [15:0] OFS_OPERAND  = 16'h0020;
  localparam logic [15:0] OFS_RESULT_H = 16'h0028;
  localparam logic [15:0] OFS_RESULT_L = 16'h0030;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_WR_OPND = 4'd1;
  localparam logic [3:0] S_WR_IEN  = 4'd2;
  localparam logic [3:0] S_WR_GO   = 4'd3;
  localparam logic [3:0] S_WAIT    = 4'd4;
  localparam logic [3:0] S_RD_DONE = 4'd5;
  localparam logic [3:0] S_RD_H    = 4'd6;
  localparam logic [3:0] S_RD_L    = 4'd7;
  localparam logic [3:0] S_WR_MH   = 4'd8;
  localparam logic [3:0] S_WR_ML   = 4'd9;
  localparam logic [3:0] S_WR_CLR  = 4'd10;
  localparam logic [3:0] S_FIN     = 4'd11;

  logic [3:0]    state, state_nxt;
  logic [63:0]   op_q, op_nxt;
  logic [15:0]   dst_q, dst_nxt;
  logic          imode_q, imode_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic          err_q, err_nxt;
  logic          busy_nxt, done_nxt, error_nxt;
  logic [63:0]   res_h_nxt, res_l_nxt;
  logic          req_nxt, wr_nxt;
  logic [15:0]   addr_nxt;
  logic [63:0]   dout_nxt;
  logic          xfer_c;
  logic          tmo_hit_c;

  assign xfer_c    = m_req & m_grant;
  assign tmo_hit_c = (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      imode_q  <= 1'b0;
      gap_cnt  <= '0;
      tmo_cnt  <= '0;
      err_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      result_h <= '0;
      result_l <= '0;
      m_req    <= 1'b0;
      m_wr     <= 1'b0;
      m_addr   <= '0;
      m_dout   <= '0;
    end else begin
      state    <= state_nxt;
      op_q     <= op_nxt;
      dst_q    <= dst_nxt;
      imode_q  <= imode_nxt;
      gap_cnt  <= gap_nxt;
      tmo_cnt  <= tmo_nxt;
      err_q    <= err_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      error    <= error_nxt;
      result_h <= res_h_nxt;
      result_l <= res_l_nxt;
      m_req    <= req_nxt;
      m_wr     <= wr_nxt;
      m_addr   <= addr_nxt;
      m_dout   <= dout_nxt;
    end
  end

  // Next state; every bus state advances only on its completing edge.
  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    dst_nxt   = dst_q;
    imode_nxt = imode_q;
    gap_nxt   = gap_cnt;
    tmo_nxt   = tmo_cnt;
    err_nxt   = err_q;
    error_nxt = error;
    res_h_nxt = result_h;
    res_l_nxt = result_l;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_WR_OPND;
          op_nxt    = operand;
          dst_nxt   = dst_addr;
          imode_nxt = intr_mode;
          err_nxt   = 1'b0;
          error_nxt = 1'b0;
        end
      end
      S_WR_OPND: if (xfer_c) state_nxt = S_WR_IEN;
      S_WR_IEN:  if (xfer_c) state_nxt = S_WR_GO;
      S_WR_GO: begin
        if (xfer_c) begin
          state_nxt = S_WAIT;
          tmo_nxt   = '0;
          gap_nxt   = '0;
        end
      end
      S_WAIT: begin
        tmo_nxt = tmo_cnt + TW'(1);
        if (tmo_hit_c) begin
          state_nxt = S_WR_CLR;
          err_nxt   = 1'b1;
          res_h_nxt = '0;
          res_l_nxt = '0;
        end else if (imode_q) begin
          if (interrupt) state_nxt = S_RD_H;
        end else if (gap_cnt == GW'(POLL_GAP - 1)) begin
          state_nxt = S_RD_DONE;
          gap_nxt   = '0;
        end else begin
          gap_nxt = gap_cnt + GW'(1);
        end
      end
      S_RD_DONE: begin
        tmo_nxt = tmo_cnt + TW'(1);
        // Timeout wins over a read still waiting for grant.
        if (tmo_hit_c) begin
          state_nxt = S_WR_CLR;
          err_nxt   = 1'b1;
          res_h_nxt = '0;
          res_l_nxt = '0;
        end else if (xfer_c) begin
          state_nxt = m_din[0] ? S_RD_H : S_WAIT;
        end
      end
      S_RD_H: begin
        if (xfer_c) begin
          state_nxt = S_RD_L;
          res_h_nxt = m_din;
        end
      end
      S_RD_L: begin
        if (xfer_c) begin
          state_nxt = S_WR_MH;
          res_l_nxt = m_din;
        end
      end
      S_WR_MH:  if (xfer_c) state_nxt = S_WR_ML;
      S_WR_ML:  if (xfer_c) state_nxt = S_WR_CLR;
      S_WR_CLR: if (xfer_c) state_nxt = S_FIN;
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    if (state_nxt == S_FIN && err_nxt) error_nxt = 1'b1;
  end

  // Registered bus request and status derived from the state being entered.
  always_comb begin
    req_nxt  = 1'b0;
    wr_nxt   = 1'b0;
    addr_nxt = '0;
    dout_nxt = '0;
    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_FIN);

    case (state_nxt)
      S_WR_OPND: begin
        req_nxt  = 1'b1;
        wr_nxt   = 1'b1;
        addr_nxt = FACT_BASE + OFS_OPERAND;
        dout_nxt = op_nxt;
      end
      S_WR_IEN: begin
        req_nxt  = 1'b1;
        wr_nxt   = 1'b1;
        addr_nxt = FACT_BASE + OFS_INTREN;
        dout_nxt = {63'b0, imode_nxt};
      end
      S_WR_GO: begin
        req_nxt  = 1'b1;
        wr_nxt   = 1'b1;
        addr_nxt = FACT_BASE + OFS_OPSTART;
        dout_nxt = 64'd1;
      end
      S_RD_DONE: begin
        req_nxt  = 1'b1;
        addr_nxt = FACT_BASE + OFS_OPDONE;
      end
      S_RD_H: begin
        req_nxt  = 1'b1;
        addr_nxt = FACT_BASE + OFS_RESULT_H;
      end
      S_RD_L: begin
        req_nxt  = 1'b1;
        addr_nxt = FACT_BASE + OFS_RESULT_L;
      end
      S_WR_MH: begin
        req_nxt  = 1'b1;
        wr_nxt   = 1'b1;
        addr_nxt = dst_nxt;
        dout_nxt = res_h_nxt;
      end
      S_WR_ML: begin
        req_nxt  = 1'b1;
        wr_nxt   = 1'b1;
        addr_nxt = dst_nxt + 16'd1;
        dout_nxt = res_l_nxt;
      end
      S_WR_CLR: begin
        req_nxt  = 1'b1;
        wr_nxt   = 1'b1;
        addr_nxt = FACT_BASE + OFS_OPCLEAR;
        dout_nxt = 64'd1;
      end
      default: begin
        req_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fact_job_sequencer.sv
// Bench for fact_job_sequencer: behavioural factorial core plus bus responder
// with optional grant stalls, table-driven jobs and directed corner sequences.
module tb_fact_job_sequencer;

  localparam logic [15:0] BASE      = 16'h7000;
  localparam int          STALL_CYC = 5;
  localparam int          CORE_LAT  = 20;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [63:0] data;
  } xfer_t;

  typedef struct {
    logic [63:0] op;
    logic [15:0] dst;
    logic        imode;
    logic        stall;
    logic [63:0] exp_h;
    logic [63:0] exp_l;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] operand = '0;
  logic [15:0] dst_addr = '0;
  logic        intr_mode = 1'b0;
  logic        busy, done, error;
  logic [63:0] result_h, result_l;
  logic        m_req, m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_dout;
  logic        m_grant = 1'b0;
  logic [63:0] m_din = '0;
  logic        interrupt;

  logic         stall_mode = 1'b0;
  logic         never_done = 1'b0;
  logic         intr_force = 1'b0;
  logic         core_done = 1'b0;
  logic         core_ien = 1'b0;
  logic         core_run = 1'b0;
  int           core_cnt = 0;
  logic [63:0]  core_op = '0;
  logic [127:0] core_res = '0;
  logic         held = 1'b0;
  logic [80:0]  hold_x = '0;
  int           wait_cnt = 0;
  int           stab_err = 0;
  int           stall_edges = 0;
  xfer_t        log_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  vec_t         vecs[6];

  fact_job_sequencer #(.FACT_BASE(16'h7000), .POLL_GAP(8), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .start(start), .operand(operand),
    .dst_addr(dst_addr), .intr_mode(intr_mode), .busy(busy), .done(done),
    .error(error), .result_h(result_h), .result_l(result_l), .m_req(m_req),
    .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout), .m_grant(m_grant),
    .m_din(m_din), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  assign interrupt = (core_done & core_ien) | intr_force;

  function automatic logic [127:0] fact(input logic [63:0] n);
    logic [127:0] r;
    r = 128'd1;
    for (longint unsigned i = 2; i <= n; i++) r = r * 128'(i);
    return r;
  endfunction

  function automatic xfer_t mk(input logic wr, input logic [15:0] a, input logic [63:0] d);
    return {wr, a, d};
  endfunction

  // Core model and bus responder: grant/read data at negedge, transfers at posedge.
  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (reset) begin
        held = 1'b0;
        wait_cnt = 0;
      end else begin
        if (held && (!m_req || {m_wr, m_addr, m_dout} !== hold_x)) stab_err++;
        if (m_req && !m_grant) begin
          held = 1'b1;
          hold_x = {m_wr, m_addr, m_dout};
          stall_edges++;
        end else begin
          held = 1'b0;
        end
        if (core_run) begin
          if (core_cnt == 0) begin
            core_run  <= 1'b0;
            core_done <= !never_done;
          end else begin
            core_cnt <= core_cnt - 1;
          end
        end
        if (m_req && m_grant) begin
          wait_cnt = 0;
          log_q.push_back(mk(m_wr, m_addr, m_wr ? m_dout : m_din));
          if (m_wr) begin
            if (m_addr == BASE + 16'h20) core_op <= m_dout;
            else if (m_addr == BASE + 16'h18) core_ien <= m_dout[0];
            else if (m_addr == BASE) begin
              core_run  <= 1'b1;
              core_cnt  <= CORE_LAT;
              core_done <= 1'b0;
              core_res  <= fact(core_op);
            end else if (m_addr == BASE + 16'h08) begin
              core_done <= 1'b0;
              core_run  <= 1'b0;
            end
          end
        end
      end
    end else begin
      if (!m_req) begin
        m_grant = !stall_mode;
        wait_cnt = 0;
      end else if (!stall_mode || wait_cnt >= STALL_CYC) begin
        m_grant = 1'b1;
      end else begin
        m_grant = 1'b0;
        wait_cnt++;
      end
      if (m_addr == BASE + 16'h10) m_din = {63'b0, core_done};
      else if (m_addr == BASE + 16'h28) m_din = core_res[127:64];
      else if (m_addr == BASE + 16'h30) m_din = core_res[63:0];
      else m_din = 64'hDEAD_BEEF_0000_0000;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic launch(input vec_t v);
    stall_mode = v.stall;
    @(negedge clk);
    start = 1'b1;
    operand = v.op;
    dst_addr = v.dst;
    intr_mode = v.imode;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("first_req", {m_req, m_wr, m_addr}, {1'b1, 1'b1, BASE + 16'h20});
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = done;
    end
    check({name, "_done_seen"}, seen, 1);
  endtask

  task automatic check_job(input vec_t v, input int base, input string name);
    int    n, nmid, bad;
    xfer_t e[8];
    n = log_q.size() - base;
    check({name, "_error"}, error, 0);
    check({name, "_result_h"}, result_h, v.exp_h);
    check({name, "_result_l"}, result_l, v.exp_l);
    e[0] = mk(1'b1, BASE + 16'h20, v.op);
    e[1] = mk(1'b1, BASE + 16'h18, {63'b0, v.imode});
    e[2] = mk(1'b1, BASE, 64'd1);
    e[3] = mk(1'b0, BASE + 16'h28, v.exp_h);
    e[4] = mk(1'b0, BASE + 16'h30, v.exp_l);
    e[5] = mk(1'b1, v.dst, v.exp_h);
    e[6] = mk(1'b1, 16'(v.dst + 16'd1), v.exp_l);
    e[7] = mk(1'b1, BASE + 16'h08, 64'd1);
    check({name, "_bus_len_ge8"}, n >= 8, 1);
    if (n >= 8) begin
      for (int i = 0; i < 3; i++)
        check($sformatf("%s_head%0d", name, i), log_q[base + i], e[i]);
      for (int i = 0; i < 5; i++)
        check($sformatf("%s_tail%0d", name, i), log_q[base + n - 5 + i], e[3 + i]);
      nmid = n - 8;
      bad = 0;
      for (int i = 0; i < nmid; i++)
        if (log_q[base + 3 + i].wr || log_q[base + 3 + i].addr != BASE + 16'h10) bad++;
      if (v.imode) begin
        check({name, "_no_opdone_reads"}, nmid, 0);
      end else begin
        check({name, "_poll_reads_present"}, nmid >= 1, 1);
        check({name, "_poll_reads_opdone"}, bad, 0);
        if (nmid >= 1) check({name, "_last_poll_done"}, log_q[base + n - 6].data, 1);
      end
    end
    @(posedge clk);
    #1;
    check({name, "_busy_done_low_after"}, {busy, done}, 2'b00);
  endtask

  initial begin
    vec_t v;
    int   base, n, dst_wr;
    bit   got;

    vecs[0] = '{64'd7,  16'h0080, 1'b0, 1'b0, 64'd0, 64'd5040};
    vecs[1] = '{64'd20, 16'h0100, 1'b1, 1'b0, 64'd0, 64'd2432902008176640000};
    vecs[2] = '{64'd7,  16'h0080, 1'b0, 1'b1, 64'd0, 64'd5040};
    vecs[3] = '{64'd20, 16'h0200, 1'b1, 1'b1, 64'd0, 64'd2432902008176640000};
    vecs[4] = '{64'd21, 16'hFFFF, 1'b0, 1'b0, 64'd2, 64'd14197454024290336768};
    vecs[5] = '{64'd0,  16'h0010, 1'b1, 1'b1, 64'd0, 64'd1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_bus", {m_req, m_wr, m_addr, m_dout}, '0);
    check("rst_status", {busy, done, error}, 3'b000);
    check("rst_results", {result_h, result_l}, '0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 6; k++) begin
      base = log_q.size();
      launch(vecs[k]);
      wait_done($sformatf("vec%0d", k));
      check_job(vecs[k], base, $sformatf("vec%0d", k));
    end
    check("stall_stable", stab_err, 0);
    check("stall_exercised", stall_edges > 0, 1);

    // Interrupt-to-done latency with grant tied high.
    v = '{64'd20, 16'h0500, 1'b1, 1'b0, 64'd0, 64'd2432902008176640000};
    base = log_q.size();
    launch(v);
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(posedge clk);
      #1;
      got = interrupt;
    end
    check("intr_seen", got, 1);
    @(posedge clk);
    #1;
    check("rdh_req_after_intr", {m_req, m_wr, m_addr}, {1'b1, 1'b0, BASE + 16'h28});
    repeat (4) @(posedge clk);
    #1;
    check("done_not_early", done, 0);
    @(posedge clk);
    #1;
    check("done_6_after_intr", done, 1);
    check_job(v, base, "intr_timing");

    // Core never completes; a stray interrupt in poll mode must not help.
    v = '{64'd5, 16'h0400, 1'b0, 1'b0, 64'd0, 64'd0};
    never_done = 1'b1;
    intr_force = 1'b1;
    base = log_q.size();
    launch(v);
    wait_done("timeout");
    check("timeout_error", error, 1);
    check("timeout_results", {result_h, result_l}, '0);
    n = log_q.size() - base;
    dst_wr = 0;
    for (int i = 0; i < n; i++)
      if (log_q[base + i].wr && (log_q[base + i].addr == 16'h0400 || log_q[base + i].addr == 16'h0401))
        dst_wr++;
    check("timeout_no_dst_writes", dst_wr, 0);
    check("timeout_bus_len", n > 0, 1);
    if (n > 0) check("timeout_opclear", log_q[base + n - 1], mk(1'b1, BASE + 16'h08, 64'd1));
    never_done = 1'b0;
    intr_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("error_held", {error, done, busy}, 3'b100);

    // Start pulsed during WAIT is ignored.
    base = log_q.size();
    launch(vecs[0]);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      #1;
      got = m_req && m_wr && (m_addr == BASE);
    end
    check("go_seen", got, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    operand = 64'd9;
    dst_addr = 16'h0300;
    intr_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("start_in_wait");
    check_job(vecs[0], base, "start_in_wait");

    // Reset during RD_L, then a clean job.
    v = vecs[4];
    v.dst = 16'h0600;
    launch(v);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      got = m_req && !m_wr && (m_addr == BASE + 16'h30);
    end
    check("rdl_seen", got, 1);
    check("result_h_before_reset", result_h, 2);
    reset = 1'b1;
    #1;
    check("midrst_m_req", m_req, 0);
    check("midrst_bus", {m_wr, m_addr, m_dout}, '0);
    check("midrst_status", {busy, done, error}, 3'b000);
    check("midrst_results", {result_h, result_l}, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    base = log_q.size();
    launch(vecs[0]);
    wait_done("after_reset");
    check_job(vecs[0], base, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
